// File: rtl/exec_alu_pkg.sv
// exec_alu_pkg: opcode encodings, RFLAGS bit positions and reset value,
// and the shift/rotate selector shared by exec_alu and exec_alu_shifter.
package exec_alu_pkg;

    localparam int OPCODE_W = 8;
    localparam int DATA_W   = 64;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 8'd0,
        OP_MOV  = 8'd1,
        OP_LEA  = 8'd2,
        OP_ADD  = 8'd3,
        OP_ADC  = 8'd4,
        OP_SUB  = 8'd5,
        OP_SBB  = 8'd6,
        OP_CMP  = 8'd7,
        OP_AND  = 8'd8,
        OP_OR   = 8'd9,
        OP_XOR  = 8'd10,
        OP_TEST = 8'd11,
        OP_INC  = 8'd12,
        OP_DEC  = 8'd13,
        OP_NEG  = 8'd14,
        OP_NOT  = 8'd15,
        OP_SHL  = 8'd16,
        OP_SHR  = 8'd17,
        OP_SAR  = 8'd18,
        OP_ROL  = 8'd19,
        OP_ROR  = 8'd20,
        OP_MUL  = 8'd21,
        OP_IMUL = 8'd22
    } opcode_e;

    typedef enum logic [2:0] {
        SH_SHL = 3'd0,
        SH_SHR = 3'd1,
        SH_SAR = 3'd2,
        SH_ROL = 3'd3,
        SH_ROR = 3'd4
    } shift_kind_e;

    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 2;
    localparam int FLAG_AF = 4;
    localparam int FLAG_ZF = 6;
    localparam int FLAG_SF = 7;
    localparam int FLAG_OF = 11;

    // Bit 1 of RFLAGS is reserved and always reads as one.
    localparam logic [63:0] RFLAGS_RESET = 64'h2;

    // PF is set when the low byte holds an even number of ones.
    function automatic logic parity_even(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/exec_alu_shifter.sv
// exec_alu_shifter: combinational 64-bit shift/rotate unit. Returns the
// shifted value and the last bit moved out (CF). The caller handles the
// count==0 case, where CF is meaningless.
module exec_alu_shifter
    import exec_alu_pkg::*;
(
    input  logic [63:0]  value,
    input  logic [5:0]   count,
    input  shift_kind_e  kind,
    output logic [63:0]  shifted,
    output logic         carry
);

    logic [64:0]        shl_ext;
    logic [64:0]        shr_ext;
    logic signed [64:0] sar_src;
    logic signed [64:0] sar_ext;
    logic [63:0]        rol_val;
    logic [63:0]        ror_val;
    logic [6:0]         back_cnt;

    // The extra bit on each extended word catches the last bit shifted out.
    always_comb begin
        back_cnt = 7'd64 - {1'b0, count};
        shl_ext  = {1'b0, value} << count;
        shr_ext  = {value, 1'b0} >> count;
        sar_src  = {value, 1'b0};
        sar_ext  = sar_src >>> count;
        rol_val  = (value << count) | (value >> back_cnt);
        ror_val  = (value >> count) | (value << back_cnt);
    end

    // Select value and carry-out for the requested operation.
    always_comb begin
        shifted = value;
        carry   = 1'b0;
        case (kind)
            SH_SHL: begin
                shifted = shl_ext[63:0];
                carry   = shl_ext[64];
            end
            SH_SHR: begin
                shifted = shr_ext[64:1];
                carry   = shr_ext[0];
            end
            SH_SAR: begin
                shifted = sar_ext[64:1];
                carry   = sar_ext[0];
            end
            SH_ROL: begin
                shifted = rol_val;
                carry   = rol_val[0];
            end
            SH_ROR: begin
                shifted = ror_val;
                carry   = ror_val[63];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/exec_alu.sv
// exec_alu: zero-latency 64-bit integer execute unit with the architectural
// RFLAGS register. Optional macro EXEC_ALU_MUL_EN builds the MUL/IMUL
// multiplier; without it those opcodes behave as unknown opcodes.
module exec_alu
    import exec_alu_pkg::*;
#(
    parameter int OPCODE_W = 8,
    parameter int DATA_W   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DATA_W-1:0]   oprd1,
    input  logic [DATA_W-1:0]   oprd2,
    input  logic [DATA_W-1:0]   oprd3,
    output logic [127:0]        result,
    output logic [63:0]         flags,
    output logic                valid
);

    opcode_e     op;
    logic [63:0] rflags;

    logic [63:0] arith_a;
    logic [63:0] arith_b;
    logic        arith_cin;
    logic        arith_sub;
    logic [63:0] arith_b_eff;
    logic        arith_c_eff;
    logic [64:0] arith_full;
    logic [63:0] arith_sum;
    logic        arith_cf;
    logic        arith_af;
    logic        arith_of;

    shift_kind_e sh_kind;
    logic [5:0]  sh_count;
    logic [63:0] sh_value;
    logic        sh_carry;

    logic [63:0] logic_val;
    logic [63:0] szp_src;
    logic        upd_szp;
    logic [127:0] res;
    logic [63:0]  nf;

`ifdef EXEC_ALU_MUL_EN
    logic [127:0]        prod_u;
    logic signed [127:0] prod_s;
`endif

    assign op       = opcode_e'(opcode);
    assign sh_count = oprd2[5:0];

    // Steer the shared adder: subtraction is a + ~b + ~borrow_in.
    always_comb begin
        arith_a   = oprd1;
        arith_b   = oprd2;
        arith_cin = 1'b0;
        arith_sub = 1'b0;
        case (op)
            OP_ADC: arith_cin = rflags[FLAG_CF];
            OP_SUB, OP_CMP: arith_sub = 1'b1;
            OP_SBB: begin
                arith_sub = 1'b1;
                arith_cin = rflags[FLAG_CF];
            end
            OP_INC: arith_b = 64'd1;
            OP_DEC: begin
                arith_sub = 1'b1;
                arith_b   = 64'd1;
            end
            OP_NEG: begin
                arith_sub = 1'b1;
                arith_a   = 64'd0;
                arith_b   = oprd1;
            end
            default: ;
        endcase
    end

    // Single adder; CF is carry-out for add and inverted carry (borrow) for sub.
    always_comb begin
        arith_b_eff = arith_sub ? ~arith_b : arith_b;
        arith_c_eff = arith_sub ? ~arith_cin : arith_cin;
        arith_full  = {1'b0, arith_a} + {1'b0, arith_b_eff} + {64'd0, arith_c_eff};
        arith_sum   = arith_full[63:0];
        arith_cf    = arith_full[64] ^ arith_sub;
        arith_af    = arith_a[4] ^ arith_b[4] ^ arith_sum[4];
        arith_of    = (arith_a[63] == arith_b_eff[63]) && (arith_sum[63] != arith_a[63]);
    end

    // Map the opcode onto the shifter operation.
    always_comb begin
        sh_kind = SH_SHL;
        case (op)
            OP_SHR:  sh_kind = SH_SHR;
            OP_SAR:  sh_kind = SH_SAR;
            OP_ROL:  sh_kind = SH_ROL;
            OP_ROR:  sh_kind = SH_ROR;
            default: sh_kind = SH_SHL;
        endcase
    end

    exec_alu_shifter u_shifter (
        .value   (oprd1),
        .count   (sh_count),
        .kind    (sh_kind),
        .shifted (sh_value),
        .carry   (sh_carry)
    );

    // Bitwise ops; TEST shares the AND path.
    always_comb begin
        logic_val = oprd1 & oprd2;
        case (op)
            OP_OR:   logic_val = oprd1 | oprd2;
            OP_XOR:  logic_val = oprd1 ^ oprd2;
            default: logic_val = oprd1 & oprd2;
        endcase
    end

`ifdef EXEC_ALU_MUL_EN
    // Full-width products; the operands are extended to 128 bits first.
    always_comb begin
        prod_u = {64'd0, oprd1} * {64'd0, oprd2};
        prod_s = $signed(oprd1) * $signed(oprd2);
    end
`endif

    // Result and next-flags selection. Flags not touched by an op pass
    // through from rflags, which also covers unknown opcodes.
    always_comb begin
        res     = 128'd0;
        nf      = rflags;
        upd_szp = 1'b0;
        szp_src = 64'd0;
        case (op)
            OP_NOP: res[63:0] = oprd1;
            OP_MOV: res[63:0] = oprd2;
            OP_LEA: res[63:0] = oprd2 + oprd3;
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP, OP_NEG: begin
                // CMP writes back oprd1 unchanged so the writeback is harmless.
                res[63:0]   = (op == OP_CMP) ? oprd1 : arith_sum;
                nf[FLAG_CF] = arith_cf;
                nf[FLAG_AF] = arith_af;
                nf[FLAG_OF] = arith_of;
                upd_szp     = 1'b1;
                szp_src     = arith_sum;
            end
            OP_INC, OP_DEC: begin
                res[63:0]   = arith_sum;
                nf[FLAG_AF] = arith_af;
                nf[FLAG_OF] = arith_of;
                upd_szp     = 1'b1;
                szp_src     = arith_sum;
            end
            OP_AND, OP_OR, OP_XOR, OP_TEST: begin
                res[63:0]   = (op == OP_TEST) ? oprd1 : logic_val;
                nf[FLAG_CF] = 1'b0;
                nf[FLAG_AF] = 1'b0;
                nf[FLAG_OF] = 1'b0;
                upd_szp     = 1'b1;
                szp_src     = logic_val;
            end
            OP_NOT: res[63:0] = ~oprd1;
            OP_SHL, OP_SHR, OP_SAR: begin
                res[63:0] = oprd1;
                if (sh_count != 6'd0) begin
                    res[63:0]   = sh_value;
                    nf[FLAG_CF] = sh_carry;
                    nf[FLAG_AF] = 1'b0;
                    upd_szp     = 1'b1;
                    szp_src     = sh_value;
                    case (op)
                        OP_SHL:  nf[FLAG_OF] = sh_value[63] ^ sh_carry;
                        OP_SHR:  nf[FLAG_OF] = oprd1[63];
                        default: nf[FLAG_OF] = 1'b0;
                    endcase
                end
            end
            OP_ROL, OP_ROR: begin
                res[63:0] = oprd1;
                if (sh_count != 6'd0) begin
                    res[63:0]   = sh_value;
                    nf[FLAG_CF] = sh_carry;
                    nf[FLAG_OF] = sh_value[63] ^ sh_value[62];
                end
            end
`ifdef EXEC_ALU_MUL_EN
            OP_MUL: begin
                res         = prod_u;
                nf[FLAG_CF] = (prod_u[127:64] != 64'd0);
                nf[FLAG_OF] = (prod_u[127:64] != 64'd0);
                nf[FLAG_AF] = 1'b0;
                upd_szp     = 1'b1;
                szp_src     = prod_u[63:0];
            end
            OP_IMUL: begin
                res         = prod_s;
                nf[FLAG_CF] = (prod_s[127:64] != {64{prod_s[63]}});
                nf[FLAG_OF] = (prod_s[127:64] != {64{prod_s[63]}});
                nf[FLAG_AF] = 1'b0;
                upd_szp     = 1'b1;
                szp_src     = prod_s[63:0];
            end
`endif
            default: ;
        endcase
        if (upd_szp) begin
            nf[FLAG_SF] = szp_src[63];
            nf[FLAG_ZF] = (szp_src == 64'd0);
            nf[FLAG_PF] = parity_even(szp_src[7:0]);
        end
        if (!enable) begin
            res = 128'd0;
            nf  = rflags;
        end
    end

    assign result = res;
    assign flags  = nf;
    assign valid  = enable & ~reset;

    // Architectural RFLAGS: captured only on enabled, non-reset cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            rflags <= RFLAGS_RESET;
        end else if (enable) begin
            rflags <= nf;
        end
    end

endmodule

// File: tb/tb_exec_alu.sv
// tb_exec_alu: directed scoreboard bench for exec_alu. Expected results are
// queued when each micro-op is driven and checked half a cycle later.
module tb_exec_alu;
    import exec_alu_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [7:0]   opcode;
    logic [63:0]  oprd1;
    logic [63:0]  oprd2;
    logic [63:0]  oprd3;
    logic [127:0] result;
    logic [63:0]  flags;
    logic         valid;

    int checks = 0;
    int errors = 0;

`ifdef EXEC_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        string        tag;
        logic [127:0] res;
        logic [63:0]  flg;
        logic         vld;
        bit           chk_res;
        bit           chk_flg;
    } exp_t;

    exp_t sb[$];

    exec_alu #(.OPCODE_W(8), .DATA_W(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .opcode (opcode),
        .oprd1  (oprd1),
        .oprd2  (oprd2),
        .oprd3  (oprd3),
        .result (result),
        .flags  (flags),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input string tag, input logic rst, input logic en,
                        input logic [7:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c,
                        input logic [127:0] er, input logic [63:0] ef,
                        input bit chk_res, input bit chk_flg);
        exp_t e;
        @(posedge clk);
        #1;
        reset  = rst;
        enable = en;
        opcode = op;
        oprd1  = a;
        oprd2  = b;
        oprd3  = c;
        sb.push_back('{tag, er, ef, en & ~rst, chk_res, chk_flg});
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        assert (valid === e.vld) else begin
            errors++;
            $error("FAIL %s valid: observed %0b expected %0b", e.tag, valid, e.vld);
        end
        if (e.chk_res) begin
            checks++;
            assert (result === e.res) else begin
                errors++;
                $error("FAIL %s result: observed %h expected %h", e.tag, result, e.res);
            end
        end
        if (e.chk_flg) begin
            checks++;
            assert (flags === e.flg) else begin
                errors++;
                $error("FAIL %s flags: observed %h expected %h", e.tag, flags, e.flg);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        opcode = 8'd0;
        oprd1  = 64'd0;
        oprd2  = 64'd0;
        oprd3  = 64'd0;
        repeat (2) @(posedge clk);

        step("reset_idle", 0, 0, OP_NOP, 64'h55, 0, 0, 128'd0, 64'h2, 1, 1);
        step("add_ovf", 0, 1, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0,
             128'h8000_0000_0000_0000, 64'h896, 1, 1);
        step("sub_eq", 0, 1, OP_SUB, 64'd5, 64'd5, 0, 128'd0, 64'h46, 1, 1);
        step("sbb_cf0", 0, 1, OP_SBB, 64'd0, 64'd0, 0, 128'd0, 64'h46, 1, 1);
        step("sub_borrow", 0, 1, OP_SUB, 64'd0, 64'd1, 0,
             128'hFFFF_FFFF_FFFF_FFFF, 64'h97, 1, 1);
        step("sbb_cf1", 0, 1, OP_SBB, 64'd0, 64'd0, 0,
             128'hFFFF_FFFF_FFFF_FFFF, 64'h97, 1, 1);
        step("cmp_lt", 0, 1, OP_CMP, 64'd3, 64'd7, 0, 128'd3, 64'h97, 1, 1);
        step("disabled", 0, 0, OP_ADD, 64'd1, 64'd1, 0, 128'd0, 64'h97, 1, 1);
        step("nop_hold", 0, 1, OP_NOP, 64'h1234, 0, 0, 128'h1234, 64'h97, 1, 1);
        step("shl_1", 0, 1, OP_SHL, 64'h8000_0000_0000_0001, 64'd1, 0,
             128'h2, 64'h803, 1, 1);
        step("shl_0", 0, 1, OP_SHL, 64'hABCD, 64'd64, 0, 128'hABCD, 64'h803, 1, 1);
        step("mov", 0, 1, OP_MOV, 64'h1, 64'hDEAD_BEEF, 0, 128'hDEAD_BEEF, 64'h803, 1, 1);
        step("lea", 0, 1, OP_LEA, 64'h9, 64'h100, 64'h23, 128'h123, 64'h803, 1, 1);
        step("adc_cf1", 0, 1, OP_ADC, 64'd1, 64'd1, 0, 128'd3, 64'h6, 1, 1);
        step("xor_zero", 0, 1, OP_XOR, 64'd5, 64'd5, 0, 128'd0, 64'h46, 1, 1);
        step("or_sign", 0, 1, OP_OR, 64'h8000_0000_0000_0000, 64'd1, 0,
             128'h8000_0000_0000_0001, 64'h82, 1, 1);
        step("test", 0, 1, OP_TEST, 64'hFF, 64'h0F, 0, 128'hFF, 64'h6, 1, 1);
        step("sub_setcf", 0, 1, OP_SUB, 64'd0, 64'd1, 0,
             128'hFFFF_FFFF_FFFF_FFFF, 64'h97, 1, 1);
        step("inc_ovf", 0, 1, OP_INC, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0,
             128'h8000_0000_0000_0000, 64'h897, 1, 1);
        step("dec_zero", 0, 1, OP_DEC, 64'd0, 0, 0,
             128'hFFFF_FFFF_FFFF_FFFF, 64'h97, 1, 1);
        step("neg_min", 0, 1, OP_NEG, 64'h8000_0000_0000_0000, 0, 0,
             128'h8000_0000_0000_0000, 64'h887, 1, 1);
        step("not", 0, 1, OP_NOT, 64'h0F, 0, 0,
             128'hFFFF_FFFF_FFFF_FFF0, 64'h887, 1, 1);
        step("shr_1", 0, 1, OP_SHR, 64'h8000_0000_0000_0003, 64'd1, 0,
             128'h4000_0000_0000_0001, 64'h803, 1, 1);
        step("sar_2", 0, 1, OP_SAR, 64'h8000_0000_0000_0002, 64'd2, 0,
             128'hE000_0000_0000_0000, 64'h87, 1, 1);
        step("rol_4", 0, 1, OP_ROL, 64'h8000_0000_0000_0001, 64'd4, 0,
             128'h18, 64'h86, 1, 1);
        step("ror_1", 0, 1, OP_ROR, 64'h1, 64'd1, 0,
             128'h8000_0000_0000_0000, 64'h887, 1, 1);
        step("imul", 0, 1, OP_IMUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0,
             MUL_EN ? 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE : 128'd0,
             MUL_EN ? 64'h82 : 64'h887, 1, 1);
        step("mul", 0, 1, OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0,
             MUL_EN ? 128'h1_FFFF_FFFF_FFFF_FFFE : 128'd0,
             MUL_EN ? 64'h883 : 64'h887, 1, 1);
        step("unknown_op", 0, 1, 8'hFF, 64'h77, 64'h88, 0, 128'd0,
             MUL_EN ? 64'h883 : 64'h887, 1, 1);
        step("reset_en", 1, 1, OP_ADD, 64'd1, 64'd1, 0, 128'd0, 64'd0, 0, 0);
        step("nop_after_rst", 0, 1, OP_NOP, 64'hCAFE, 0, 0, 128'hCAFE, 64'h2, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
